// File: rtl/vga_pkg.sv
// ============================================================
// Module   : vga_pkg
// Brief    : 640x480 timing constants and square scheduler FSM state.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package vga_pkg;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;

    localparam int MAX_OBJ  = 8;
    localparam int SLOT_GAP = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Slots start on a diagonal, spaced one square plus a small gap apart.
    function automatic logic [9:0] slot_origin(input int idx, input int q);
        return 10'(idx * (q + SLOT_GAP));
    endfunction

endpackage

`default_nettype wire

// File: rtl/square_step.sv
// ============================================================
// Module   : square_step
// Brief    : Combinational single-axis bounce step for one square.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module square_step #(
    parameter int Q_SIZE = 32
) (
    input  logic [9:0] pos,
    input  logic [3:0] speed,
    input  logic       dir,
    input  logic [9:0] limit,
    output logic [9:0] next_pos,
    output logic       next_dir
);

    logic [10:0] w_far;
    logic [10:0] w_edge;

    // 11-bit sums so a square near the far edge cannot wrap past zero.
    assign w_far  = {1'b0, pos} + 11'(Q_SIZE) + {7'd0, speed};
    assign w_edge = {1'b0, limit} - 11'd1;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        if (!dir) begin
            if (w_far >= w_edge) begin
                next_pos = limit - 10'(Q_SIZE) - 10'd1;
                next_dir = 1'b1;
            end else begin
                next_pos = pos + {6'd0, speed};
            end
        end else begin
            if (pos < {6'd0, speed}) begin
                next_pos = '0;
                next_dir = 1'b0;
            end else begin
                next_pos = pos - {6'd0, speed};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/square_scheduler.sv
// ============================================================
// Module   : square_scheduler
// Brief    : Per-frame bounce update and per-pixel ownership for N squares.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module square_scheduler
    import vga_pkg::state_t, vga_pkg::IDLE, vga_pkg::UPDATE, vga_pkg::DONE, vga_pkg::slot_origin;
#(
    parameter int N_OBJ     = 4,
    parameter int Q_SIZE    = 32,
    parameter int H_RES     = vga_pkg::H_RES,
    parameter int V_RES     = vga_pkg::V_RES,
    parameter int FRAME_NUM = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       de,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_idx,
    input  logic [9:0] cfg_x,
    input  logic [9:0] cfg_y,
    input  logic [3:0] cfg_speed,
    input  logic [1:0] cfg_dir,
    output logic       hit,
    output logic [2:0] hit_idx,
    output logic       busy,
    output logic       upd_done
);

    localparam int                MAX_OBJ  = vga_pkg::MAX_OBJ;
    localparam int                CNT_W    = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_NUM - 1);
    localparam logic [9:0]        X_MAX    = 10'(H_RES - Q_SIZE - 1);
    localparam logic [9:0]        Y_MAX    = 10'(V_RES - Q_SIZE - 1);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;

    logic [9:0]         r_x     [MAX_OBJ];
    logic [9:0]         r_y     [MAX_OBJ];
    logic [3:0]         r_speed [MAX_OBJ];
    logic [MAX_OBJ-1:0] r_dx;
    logic [MAX_OBJ-1:0] r_dy;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_idx;
    logic [CNT_W-1:0]   r_cnt_frame;

    logic               w_frame_tick;
    logic               w_start;
    logic               w_cfg_we;
    logic [9:0]         w_cfg_x;
    logic [9:0]         w_cfg_y;

    logic [9:0]         w_nx;
    logic [9:0]         w_ny;
    logic               w_ndx;
    logic               w_ndy;

    logic [N_OBJ-1:0]   w_in;
    logic               w_hit;
    logic [2:0]         w_hit_idx;
    logic               r_hit;
    logic [2:0]         r_hit_idx;

    // Reset asserts immediately but releases only after two clean edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_frame_tick = (counter_y == 10'(V_RES)) && (counter_x == 10'd0);
    assign w_start      = w_frame_tick && (r_cnt_frame == '0);
    assign cfg_ready    = (r_state == IDLE) && !w_frame_tick;
    assign w_cfg_we     = cfg_valid && cfg_ready && ({1'b0, cfg_idx} < 4'(N_OBJ));
    assign w_cfg_x      = (cfg_x > X_MAX) ? X_MAX : cfg_x;
    assign w_cfg_y      = (cfg_y > Y_MAX) ? Y_MAX : cfg_y;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt_frame <= '0;
        end else if (w_frame_tick) begin
            r_cnt_frame <= (r_cnt_frame == CNT_LAST) ? '0 : r_cnt_frame + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = UPDATE;
            UPDATE:  if (r_idx == 3'(N_OBJ - 1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= (r_state == UPDATE) ? r_idx + 3'd1 : 3'd0;
        end
    end

    // One stepper per axis, time-shared across slots by the update index.
    square_step #(.Q_SIZE(Q_SIZE)) u_step_x (
        .pos      (r_x[r_idx]),
        .speed    (r_speed[r_idx]),
        .dir      (r_dx[r_idx]),
        .limit    (10'(H_RES)),
        .next_pos (w_nx),
        .next_dir (w_ndx)
    );

    square_step #(.Q_SIZE(Q_SIZE)) u_step_y (
        .pos      (r_y[r_idx]),
        .speed    (r_speed[r_idx]),
        .dir      (r_dy[r_idx]),
        .limit    (10'(V_RES)),
        .next_pos (w_ny),
        .next_dir (w_ndy)
    );

    // Slots at or above N_OBJ are never written and hold their reset value.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                r_x[i]     <= slot_origin(i, Q_SIZE);
                r_y[i]     <= slot_origin(i, Q_SIZE);
                r_speed[i] <= 4'd1;
            end
            r_dx <= '0;
            r_dy <= '0;
        end else if (r_state == UPDATE) begin
            r_x[r_idx]  <= w_nx;
            r_y[r_idx]  <= w_ny;
            r_dx[r_idx] <= w_ndx;
            r_dy[r_idx] <= w_ndy;
        end else if (w_cfg_we) begin
            r_x[cfg_idx]     <= w_cfg_x;
            r_y[cfg_idx]     <= w_cfg_y;
            r_speed[cfg_idx] <= cfg_speed;
            r_dx[cfg_idx]    <= cfg_dir[0];
            r_dy[cfg_idx]    <= cfg_dir[1];
        end
    end

    generate
        for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_slot
            assign w_in[gi] = (counter_x >= r_x[gi])
                           && ({1'b0, counter_x} < ({1'b0, r_x[gi]} + 11'(Q_SIZE)))
                           && (counter_y >= r_y[gi])
                           && ({1'b0, counter_y} < ({1'b0, r_y[gi]} + 11'(Q_SIZE)));
        end
    endgenerate

    always_comb begin
        w_hit_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (w_in[i]) w_hit_idx = 3'(i);
        end
    end

    assign w_hit = de && (|w_in);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hit     <= 1'b0;
            r_hit_idx <= '0;
        end else begin
            r_hit     <= w_hit;
            r_hit_idx <= w_hit ? w_hit_idx : 3'd0;
        end
    end

    assign hit      = r_hit;
    assign hit_idx  = r_hit_idx;
    assign busy     = (r_state == UPDATE);
    assign upd_done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_square_scheduler.sv
// ============================================================
// Module   : tb_square_scheduler
// Brief    : Scoreboard bench for square_scheduler (FRAME_NUM 1 and 3).
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_square_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] counter_x;
    logic [9:0] counter_y;
    logic       de;
    logic       cfg_valid;
    logic [2:0] cfg_idx;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [3:0] cfg_speed;
    logic [1:0] cfg_dir;

    logic       cfg_ready, hit, busy, upd_done;
    logic [2:0] hit_idx;
    logic       cfg_ready3, hit3, busy3, upd_done3;
    logic [2:0] hit_idx3;

    always #20 clk = ~clk;

    square_scheduler #(.N_OBJ(4), .Q_SIZE(32), .H_RES(640), .V_RES(480), .FRAME_NUM(1)) dut (
        .clk(clk), .reset_n(reset_n), .counter_x(counter_x), .counter_y(counter_y), .de(de),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
        .cfg_y(cfg_y), .cfg_speed(cfg_speed), .cfg_dir(cfg_dir),
        .hit(hit), .hit_idx(hit_idx), .busy(busy), .upd_done(upd_done)
    );

    square_scheduler #(.N_OBJ(4), .Q_SIZE(32), .H_RES(640), .V_RES(480), .FRAME_NUM(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .counter_x(counter_x), .counter_y(counter_y), .de(de),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
        .cfg_y(cfg_y), .cfg_speed(cfg_speed), .cfg_dir(cfg_dir),
        .hit(hit3), .hit_idx(hit_idx3), .busy(busy3), .upd_done(upd_done3)
    );

    typedef struct packed {
        logic       which;
        logic       hit;
        logic [2:0] idx;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic       mon_hit;
    logic [2:0] mon_idx;
    logic       probe_v = 1'b0;
    logic       probe_q = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         b3;
    logic [5:0] pat3 = 6'b001001;

    always @(posedge clk) probe_q <= probe_v;

    // Monitor: every probe presented at an edge is judged on the following negedge.
    always @(negedge clk) begin
        if (probe_q) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: probe result present but no expectation queued");
            end else begin
                mon_e   = sb.pop_front();
                mon_hit = mon_e.which ? hit3 : hit;
                mon_idx = mon_e.which ? hit_idx3 : hit_idx;
                if (mon_hit !== mon_e.hit || mon_idx !== mon_e.idx) begin
                    n_err++;
                    $display("FAIL probe dut%0d (%0d,%0d): got hit=%0b idx=%0d, expected hit=%0b idx=%0d",
                             mon_e.which ? 3 : 1, mon_e.x, mon_e.y, mon_hit, mon_idx, mon_e.hit, mon_e.idx);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic nop();
        @(negedge clk);
        counter_x = '0;
        counter_y = '0;
        de        = 1'b0;
        probe_v   = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input bit d, input bit which,
                         input bit eh, input int ei);
        @(negedge clk);
        counter_x = 10'(x);
        counter_y = 10'(y);
        de        = d;
        probe_v   = 1'b1;
        sb.push_back({which, eh, 3'(ei), 10'(x), 10'(y)});
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int spd, input int dir);
        @(negedge clk);
        counter_x = '0;
        counter_y = '0;
        de        = 1'b0;
        probe_v   = 1'b0;
        cfg_valid = 1'b1;
        cfg_idx   = 3'(idx);
        cfg_x     = 10'(x);
        cfg_y     = 10'(y);
        cfg_speed = 4'(spd);
        cfg_dir   = 2'(dir);
        #1 chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Frame tick at cycle 0; upd_done expected at cycle N_OBJ+1 = 5.
    task automatic do_frame(input bit chk_t, input bit with_cfg, output bit busy3_seen);
        int k;
        @(negedge clk);
        counter_x = '0;
        counter_y = 10'd480;
        de        = 1'b0;
        probe_v   = 1'b0;
        if (with_cfg) cfg_valid = 1'b1;
        #1 chk("cfg_ready_at_tick", cfg_ready, 0);
        k          = 0;
        busy3_seen = 1'b0;
        do begin
            @(negedge clk);
            counter_y = '0;
            k++;
            #1;
            if (k == 1) begin
                busy3_seen = busy3;
                chk("cfg_ready_while_busy", cfg_ready, 0);
                if (chk_t) chk("busy_rise", busy, 1);
            end
        end while (!upd_done && k < 20);
        chk("upd_done_seen", upd_done, 1);
        if (chk_t) begin
            chk("upd_done_latency", k, 5);
            chk("busy_fall_with_done", busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        counter_x = '0;
        counter_y = '0;
        de        = 1'b0;
        cfg_valid = 1'b0;
        cfg_idx   = '0;
        cfg_x     = '0;
        cfg_y     = '0;
        cfg_speed = '0;
        cfg_dir   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) nop();

        chk("rst_hit", hit, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd_done", upd_done, 0);
        #1 chk("rst_cfg_ready", cfg_ready, 1);
        probe(0, 0, 1, 0, 1, 0);
        probe(40, 40, 1, 0, 1, 1);
        probe(39, 40, 1, 0, 0, 0);
        probe(40, 39, 1, 0, 0, 0);
        probe(40, 40, 0, 0, 0, 0);
        probe(120, 120, 1, 0, 1, 3);
        nop();

        // Every slot steps +1 on both axes.
        do_frame(1, 0, b3);
        probe(41, 41, 1, 0, 1, 1);
        probe(40, 41, 1, 0, 0, 0);
        probe(41, 40, 1, 0, 0, 0);
        probe(72, 72, 1, 0, 1, 1);
        probe(73, 72, 1, 0, 0, 0);
        probe(121, 121, 1, 0, 1, 3);
        nop();

        // Right-edge bounce: 606+32+4 >= 639 -> 607, then back to 603.
        cfg_write(0, 606, 300, 4, 0);
        do_frame(0, 0, b3);
        probe(607, 304, 1, 0, 1, 0);
        probe(606, 304, 1, 0, 0, 0);
        probe(638, 335, 1, 0, 1, 0);
        probe(607, 303, 1, 0, 0, 0);
        nop();
        do_frame(0, 0, b3);
        probe(603, 308, 1, 0, 1, 0);
        probe(602, 308, 1, 0, 0, 0);
        nop();

        // Top-edge bounce: y=2 moving up at 5 -> 0, direction flips down.
        cfg_write(2, 200, 2, 5, 2);
        do_frame(0, 0, b3);
        probe(205, 0, 1, 0, 1, 2);
        probe(204, 0, 1, 0, 0, 0);
        probe(236, 31, 1, 0, 1, 2);
        probe(237, 31, 1, 0, 0, 0);
        probe(205, 32, 1, 0, 0, 0);
        nop();

        // Overlap: slot 0 (30..61) and slot 1 (44..75) both cover (50,50).
        cfg_write(0, 30, 30, 0, 0);
        probe(50, 50, 1, 0, 1, 0);
        probe(50, 50, 0, 0, 0, 0);
        probe(70, 70, 1, 0, 1, 1);
        nop();

        // Config colliding with the frame tick waits until after upd_done.
        cfg_idx   = 3'd3;
        cfg_x     = 10'd700;
        cfg_y     = 10'd10;
        cfg_speed = 4'd2;
        cfg_dir   = 2'd0;
        do_frame(0, 1, b3);
        nop();
        #1 chk("cfg_ready_after_done", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        probe(607, 10, 1, 0, 1, 3);
        probe(606, 10, 1, 0, 0, 0);
        probe(638, 41, 1, 0, 1, 3);
        probe(639, 10, 1, 0, 0, 0);
        nop();

        // Reset in the middle of an update.
        @(negedge clk);
        counter_x = '0;
        counter_y = 10'd480;
        nop();
        nop();
        chk("busy_mid_update", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("busy_after_reset", busy, 0);
        chk("upd_done_after_reset", upd_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) nop();
        chk("busy_after_release", busy, 0);
        probe(0, 0, 1, 0, 1, 0);
        probe(40, 40, 1, 0, 1, 1);
        probe(39, 40, 1, 0, 0, 0);
        probe(80, 80, 1, 0, 1, 2);
        probe(120, 120, 1, 0, 1, 3);
        probe(119, 120, 1, 0, 0, 0);
        nop();

        // FRAME_NUM=3 instance updates on ticks 1 and 4 only.
        for (int j = 0; j < 6; j++) begin
            do_frame(0, 0, b3);
            chk($sformatf("frame3_busy_tick%0d", j + 1), b3, pat3[j]);
        end
        probe(42, 42, 1, 1, 1, 1);
        probe(41, 42, 1, 1, 0, 0);
        probe(46, 46, 1, 0, 1, 1);
        probe(45, 46, 1, 0, 0, 0);
        nop();
        nop();
        nop();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
